// File: rtl/raybox_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : raybox_input_ctrl_if
// Description : Signal bundle between the board-side button/timing sources
//               and the raybox input controller.
//               master : drives raw buttons and frame pulse, observes requests
//               slave  : the controller, consumes buttons, drives requests
// Signals     : btn_n[3:0]   raw active-low buttons, [3:0] = K4..K1
//               frame_start  one-cycle frame boundary pulse
//               moveL/R/F/B  registered move requests
//               debugA..D    registered debug requests
//               mode[2:0]    current controller state for LEDs
// Revision    : 1.0  initial release
// ============================================================================
interface raybox_input_ctrl_if;
    logic [3:0] btn_n;
    logic       frame_start;
    logic       moveL;
    logic       moveR;
    logic       moveF;
    logic       moveB;
    logic       debugA;
    logic       debugB;
    logic       debugC;
    logic       debugD;
    logic [2:0] mode;

    modport master (
        output btn_n, frame_start,
        input  moveL, moveR, moveF, moveB,
        input  debugA, debugB, debugC, debugD,
        input  mode
    );

    modport slave (
        input  btn_n, frame_start,
        output moveL, moveR, moveF, moveB,
        output debugA, debugB, debugC, debugD,
        output mode
    );
endinterface
`default_nettype wire

// File: rtl/raybox_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : raybox_input_ctrl
// Description : Button front end for the raybox core. Synchronises and
//               debounces the four direction buttons, then a frame-paced
//               state machine turns single presses into moves (after a grace
//               window) and two-button chords into debug modes. All requests
//               change only on frame_start cycles.
// Ports       : clk          design clock
//               reset        synchronous, active-high reset
//               bus (slave)  btn_n, frame_start in; move*/debug*/mode out
// Parameters  : DEBOUNCE_CYCLES  stable cycles required to accept a level (>=2)
//               GRACE_FRAMES     frame boundaries spent in PENDING (>=1)
// Config      : RAYBOX_DEBUG_CHORDS_EN  define to enable chord decoding and
//               the debug outputs; undefined, every combination moves.
// Revision    : 1.0  initial release
// ============================================================================
module raybox_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int GRACE_FRAMES    = 2
) (
    input  logic                clk,
    input  logic                reset,
    raybox_input_ctrl_if.slave  bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int GW = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1;
    localparam logic [CW-1:0] C_DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] C_GRACE_LAST = GW'(GRACE_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_MOVE    = 3'd2,
        ST_DEBUG1  = 3'd3,
        ST_DEBUG2  = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and debounce (levels kept in raw active-low polarity)
    // ------------------------------------------------------------------
    logic [3:0]         sync1_q, sync1_d;
    logic [3:0]         sync2_q, sync2_d;
    logic [3:0]         level_q, level_d;
    logic [3:0][CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = bus.btn_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        for (int k = 0; k < 4; k++) begin
            // Counter only runs while the synchronised level disagrees with
            // the accepted level; any agreement restarts the qualification.
            if (sync2_q[k] != level_q[k]) begin
                if (cnt_q[k] == C_DB_LAST) begin
                    level_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Debounced pressed flags: p[0]=K1 .. p[3]=K4
    logic [3:0] p;
    logic       any_p;
    logic       c1;
    logic       c2;

    assign p     = ~level_q;
    assign any_p = |p;

`ifdef RAYBOX_DEBUG_CHORDS_EN
    assign c1 = p[1] & p[2];
    assign c2 = p[0] & p[3];
`else
    assign c1 = 1'b0;
    assign c2 = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame-paced state machine
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [GW-1:0]   grace_q, grace_d;

    always_comb begin
        state_d = state_q;
        grace_d = grace_q;
        if (bus.frame_start) begin
            case (state_q)
                ST_IDLE: begin
                    if (any_p) begin
                        state_d = ST_PENDING;
                        grace_d = '0;
                    end
                end
                ST_PENDING: begin
                    // A second button arriving inside the grace window turns
                    // the press into a chord without ever emitting a move.
                    if (c1)                         state_d = ST_DEBUG1;
                    else if (c2)                    state_d = ST_DEBUG2;
                    else if (!any_p)                state_d = ST_IDLE;
                    else if (grace_q == C_GRACE_LAST) state_d = ST_MOVE;
                    else                            grace_d = grace_q + 1'b1;
                end
                ST_MOVE: begin
                    if (c1)          state_d = ST_DEBUG1;
                    else if (c2)     state_d = ST_DEBUG2;
                    else if (!any_p) state_d = ST_IDLE;
                end
                ST_DEBUG1: begin
                    if (!(p[1] & p[2])) state_d = ST_RELEASE;
                end
                ST_DEBUG2: begin
                    if (!(p[0] & p[3])) state_d = ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Leftover held buttons must not leak into moves.
                    if (!any_p) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output registers, loaded only on frame boundaries
    // move vector = {L, R, F, B}
    // ------------------------------------------------------------------
    logic [3:0] move_q, move_d;

    always_comb begin
        move_d = move_q;
        if (bus.frame_start) begin
            move_d = (state_d == ST_MOVE) ? {p[2], p[1], p[3], p[0]} : 4'b0000;
        end
    end

`ifdef RAYBOX_DEBUG_CHORDS_EN
    // debug vector = {A, B, C, D}
    logic [3:0] dbg_q, dbg_d;

    always_comb begin
        dbg_d = dbg_q;
        if (bus.frame_start) begin
            case (state_d)
                ST_DEBUG1: dbg_d = {p[3], p[0], 2'b00};
                ST_DEBUG2: dbg_d = {2'b00, p[1], p[2]};
                default:   dbg_d = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) dbg_q <= 4'b0000;
        else       dbg_q <= dbg_d;
    end

    assign bus.debugA = dbg_q[3];
    assign bus.debugB = dbg_q[2];
    assign bus.debugC = dbg_q[1];
    assign bus.debugD = dbg_q[0];
`else
    assign bus.debugA = 1'b0;
    assign bus.debugB = 1'b0;
    assign bus.debugC = 1'b0;
    assign bus.debugD = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            level_q <= 4'hF;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            grace_q <= '0;
            move_q  <= 4'b0000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            grace_q <= grace_d;
            move_q  <= move_d;
        end
    end

    assign bus.moveL = move_q[3];
    assign bus.moveR = move_q[2];
    assign bus.moveF = move_q[1];
    assign bus.moveB = move_q[0];
    assign bus.mode  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_raybox_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_raybox_input_ctrl
// Description : Directed self-checking bench for raybox_input_ctrl with
//               DEBOUNCE_CYCLES=4, GRACE_FRAMES=2, frames of 20 cycles.
//               Observed vector = {mode[2:0], L, R, F, B, A, B, C, D}.
// Revision    : 1.0  initial release
// ============================================================================
module tb_raybox_input_ctrl;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int GRACE_FRAMES    = 2;

    logic clk = 1'b0;
    logic reset;

    raybox_input_ctrl_if bus ();

    raybox_input_ctrl #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .GRACE_FRAMES    (GRACE_FRAMES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_v;

    function automatic logic [10:0] obs();
        return {bus.mode, bus.moveL, bus.moveR, bus.moveF, bus.moveB,
                bus.debugA, bus.debugB, bus.debugC, bus.debugD};
    endfunction

    // One clock: inputs applied now are sampled at the next posedge,
    // outputs are observed at the following negedge.
    task automatic tick(input logic fs);
        bus.frame_start = fs;
        @(posedge clk);
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic frame();
        repeat (19) tick(1'b0);
        tick(1'b1);
    endtask

    task automatic do_reset();
        bus.btn_n = 4'hF;
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.btn_n = 4'hF;
        bus.frame_start = 1'b0;
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        exp_v = 11'd0;
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", obs(), exp_v);
        end
        reset = 1'b0;
        tick(1'b1);
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", obs(), exp_v);
        end
    endtask

    task automatic test_debounce();
        do_reset();
        // 3-cycle glitch must be ignored
        bus.btn_n[0] = 1'b0;
        repeat (3) tick(1'b0);
        bus.btn_n[0] = 1'b1;
        repeat (10) tick(1'b0);
        tick(1'b1);
        exp_v = 11'd0;
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL glitch_ignored: got %b expected %b", obs(), exp_v);
        end
        // Held press with frame_start high: P1 rises at edge 6, PENDING at 7
        bus.btn_n[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1);
            exp_v = 11'd0;
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL debounce_wait edge %0d: got %b expected %b", i, obs(), exp_v);
            end
        end
        tick(1'b1);
        exp_v = {3'd1, 8'b0000_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL debounce_pending: got %b expected %b", obs(), exp_v);
        end
        tick(1'b1);
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL debounce_grace: got %b expected %b", obs(), exp_v);
        end
        tick(1'b1);
        exp_v = {3'd2, 8'b0001_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL debounce_move: got %b expected %b", obs(), exp_v);
        end
        // Release also needs the full debounce before IDLE
        bus.btn_n = 4'hF;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL release_wait edge %0d: got %b expected %b", i, obs(), exp_v);
            end
        end
        tick(1'b1);
        exp_v = 11'd0;
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL release_idle: got %b expected %b", obs(), exp_v);
        end
    endtask

    task automatic test_grace_paced();
        do_reset();
        bus.btn_n[0] = 1'b0;
        frame();
        exp_v = {3'd1, 8'b0000_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL paced_pending: got %b expected %b", obs(), exp_v);
        end
        frame();
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL paced_grace: got %b expected %b", obs(), exp_v);
        end
        repeat (19) tick(1'b0);
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL paced_before_edge: got %b expected %b", obs(), exp_v);
        end
        tick(1'b1);
        exp_v = {3'd2, 8'b0001_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL paced_moveB: got %b expected %b", obs(), exp_v);
        end
        bus.btn_n = 4'hF;
        frame();
        exp_v = 11'd0;
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL paced_release: got %b expected %b", obs(), exp_v);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.btn_n[3] = 1'b0;
        repeat (3) frame();
        exp_v = {3'd2, 8'b0010_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL moveF: got %b expected %b", obs(), exp_v);
        end
        // Brief release bounce while moving is ignored
        bus.btn_n[3] = 1'b1;
        repeat (3) tick(1'b0);
        bus.btn_n[3] = 1'b0;
        repeat (16) tick(1'b0);
        tick(1'b1);
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL move_bounce: got %b expected %b", obs(), exp_v);
        end
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        exp_v = 11'd0;
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL reset_mid: got %b expected %b", obs(), exp_v);
        end
        frame();
        exp_v = {3'd1, 8'b0000_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL reset_reenter: got %b expected %b", obs(), exp_v);
        end
        bus.btn_n = 4'hF;
        frame();
        exp_v = 11'd0;
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL pending_abort: got %b expected %b", obs(), exp_v);
        end
    endtask

`ifdef RAYBOX_DEBUG_CHORDS_EN
    task automatic test_chord_grace();
        do_reset();
        bus.btn_n[2] = 1'b0;
        frame();
        exp_v = {3'd1, 8'b0000_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL chord_pending: got %b expected %b", obs(), exp_v);
        end
        bus.btn_n[1] = 1'b0;
        frame();
        exp_v = {3'd3, 8'b0000_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL chord_debug1: got %b expected %b", obs(), exp_v);
        end
        bus.btn_n[3] = 1'b0;
        frame();
        exp_v = {3'd3, 8'b0000_1000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL chord_debugA: got %b expected %b", obs(), exp_v);
        end
        bus.btn_n = 4'hF;
        frame();
        exp_v = {3'd5, 8'b0000_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL chord_release: got %b expected %b", obs(), exp_v);
        end
        frame();
        exp_v = 11'd0;
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL chord_idle: got %b expected %b", obs(), exp_v);
        end
    endtask

    task automatic test_release_discipline();
        do_reset();
        bus.btn_n = 4'b0110;
        frame();
        exp_v = {3'd1, 8'b0000_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL d2_pending: got %b expected %b", obs(), exp_v);
        end
        frame();
        exp_v = {3'd4, 8'b0000_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL d2_enter: got %b expected %b", obs(), exp_v);
        end
        bus.btn_n[3] = 1'b1;
        frame();
        exp_v = {3'd5, 8'b0000_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL d2_release: got %b expected %b", obs(), exp_v);
        end
        frame();
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL d2_hold_no_move: got %b expected %b", obs(), exp_v);
        end
        bus.btn_n[0] = 1'b1;
        frame();
        exp_v = 11'd0;
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL d2_idle: got %b expected %b", obs(), exp_v);
        end
    endtask

    task automatic test_priority();
        do_reset();
        bus.btn_n = 4'b0000;
        frame();
        frame();
        exp_v = {3'd3, 8'b0000_1100};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL priority_c1: got %b expected %b", obs(), exp_v);
        end
        bus.btn_n = 4'hF;
        frame();
        frame();
    endtask
`else
    task automatic test_multi_move();
        do_reset();
        bus.btn_n = 4'b1001;
        frame();
        frame();
        exp_v = {3'd1, 8'b0000_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL multi_grace: got %b expected %b", obs(), exp_v);
        end
        frame();
        exp_v = {3'd2, 8'b1100_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL multi_LR: got %b expected %b", obs(), exp_v);
        end
        bus.btn_n = 4'b0000;
        frame();
        exp_v = {3'd2, 8'b1111_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL multi_all: got %b expected %b", obs(), exp_v);
        end
        bus.btn_n = 4'hF;
        frame();
        exp_v = 11'd0;
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL multi_release: got %b expected %b", obs(), exp_v);
        end
        // Staggered K3 then K2: no chord, both move after grace
        bus.btn_n[2] = 1'b0;
        frame();
        bus.btn_n[1] = 1'b0;
        frame();
        exp_v = {3'd1, 8'b0000_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL stagger_grace: got %b expected %b", obs(), exp_v);
        end
        frame();
        exp_v = {3'd2, 8'b1100_0000};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL stagger_move: got %b expected %b", obs(), exp_v);
        end
        bus.btn_n = 4'hF;
        frame();
    endtask
`endif

    initial begin
        bus.btn_n       = 4'hF;
        bus.frame_start = 1'b0;
        reset           = 1'b1;
        test_reset();
        test_debounce();
        test_grace_paced();
        test_reset_mid();
`ifdef RAYBOX_DEBUG_CHORDS_EN
        test_chord_grace();
        test_release_discipline();
        test_priority();
`else
        test_multi_move();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/raybox_input_ctrl.md
# raybox_input_ctrl

Input controller sitting between the four external direction buttons (K4..K1, active-low on GPIO) and the `raybox` core's `moveL/R/F/B` and `debugA..D` inputs. It synchronises and debounces each button and decodes two-button chords into debug modes through a frame-paced state machine. A short grace window suppresses transient single-button moves while a chord is being formed. All outputs change only at frame boundaries, so the renderer never sees a control change mid-frame.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive `clk` cycles a raw level must differ from the debounced level before it is accepted (10 ms at 25 MHz); minimum 2.
- `GRACE_FRAMES`, 2: frame boundaries a new press waits in PENDING before moves are asserted; minimum 1.
- `clk`  in  1  design clock (25 MHz pixel clock).
- `reset`  in  1  synchronous, active-high reset.
- `btn_n`  in  4  raw buttons `[3:0]` = K4..K1, active-low, asynchronous to `clk`.
- `frame_start`  in  1  one-cycle pulse per frame, from the VGA timing block.
- `moveL`, `moveR`, `moveF`, `moveB`  out  1 each  registered move requests.
- `debugA`, `debugB`, `debugC`, `debugD`  out  1 each  registered debug requests.
- `mode`  out  3  current state encoding, for LED visualisation.

## Operation
- **Synchroniser.** Two-flop synchroniser per button. Both flops reset to 1 (released).
- **Debounce.** One counter per button, of width `$clog2(DEBOUNCE_CYCLES)`.
  - Counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments. On the cycle it equals `DEBOUNCE_CYCLES-1`, the debounced level takes the synchronised level and the counter clears.
  - `P[k]` = debounced pressed, active-high. Reset value 0.
- **Chords.**
  - `c1` = P2&P3 (two middle buttons).
  - `c2` = P1&P4 (two outer buttons).
  - `any` = |P.
- **State machine.** Evaluated only on cycles with `frame_start`=1; otherwise it holds. `mode` encoding: IDLE=0, PENDING=1, MOVE=2, DEBUG1=3, DEBUG2=4, RELEASE=5.
  - IDLE: `any` → PENDING, grace counter cleared.
  - PENDING, first match wins:
    - `c1` → DEBUG1.
    - `c2` → DEBUG2.
    - `!any` → IDLE.
    - grace = `GRACE_FRAMES-1` → MOVE.
    - else grace+1.
  - MOVE, first match wins: `c1` → DEBUG1; `c2` → DEBUG2; `!any` → IDLE.
  - DEBUG1: `!(P2&P3)` → RELEASE.
  - DEBUG2: `!(P1&P4)` → RELEASE.
  - RELEASE: `!any` → IDLE. Buttons left held after a debug chord never produce moves.
- **Outputs.** Registered and loaded on `frame_start` cycles from the next state and current `P`.
  - MOVE: `moveL`=P3, `moveR`=P2, `moveF`=P4, `moveB`=P1.
  - DEBUG1: `debugA`=P4, `debugB`=P1.
  - DEBUG2: `debugC`=P2, `debugD`=P3.
  - All other states: all move and debug outputs 0. Debug outputs are 0 outside their mode.
- **Simultaneous chords.** All four buttons pressed means `c1` and `c2` are both true; `c1` wins and the next state is DEBUG1.

## Timing
- **Reset.**
  - State IDLE, `mode`=0.
  - All move and debug outputs 0.
  - Debounce counters 0; debounced levels released.
  - Grace counter 0.
  - Reset takes effect on the next `clk` edge regardless of `frame_start`. Reset mid-debounce or mid-chord discards all progress.
- **Debounced-edge latency.** A clean raw edge changes `P` exactly 2 + `DEBOUNCE_CYCLES` cycles later.
- **Output latency.**
  - An output responds on the first `frame_start` at or after the `P` change. The new value is visible the cycle after that `frame_start`.
  - A move additionally waits `GRACE_FRAMES` boundaries.
- **Bounce.** A raw glitch shorter than `DEBOUNCE_CYCLES` cycles has no effect.
- **`frame_start` held high.** The state machine steps every cycle. This is legal and is used for fast simulation.

## Configuration
- `RAYBOX_DEBUG_CHORDS_EN` defined:
  - Full behaviour above.
- Undefined:
  - `c1` and `c2` are forced to 0, so DEBUG1, DEBUG2 and RELEASE are unreachable.
  - `debugA..D` are tied to 0.
  - Any button combination produces moves. For example, K2+K3 asserts both `moveL` and `moveR`.
  - Debounce, PENDING grace and frame pacing are unchanged.

## Test plan
Common setup: `DEBOUNCE_CYCLES`=4, `GRACE_FRAMES`=2, `frame_start` every 20 cycles.

- **Reset mid-operation.** Assert `reset` while in MOVE with `moveF`=1 → the next cycle has `mode`=0 and all outputs 0. After release, K4 still held re-enters PENDING at the next `frame_start`.
- **Debounce.** Toggle `btn_n[0]` low for 3 cycles, then high → no state change. Hold it low → `P1` rises 6 cycles after the edge. `moveB`=1 follows after the second subsequent `frame_start` (grace), visible one cycle later.
- **Chord during grace.** Press K3, then K2 one frame later → PENDING → DEBUG1 with `moveL` never asserted. Then press K4 → `debugA`=1 at the next boundary.
- **Release discipline.** From DEBUG2, release K4 while holding K1 → RELEASE with all outputs 0. `mode` stays 5 until K1 is released, then 0.
- **Priority.** Press all four buttons together → `mode`=3 and `debugA`=`debugB`=1. `debugC`/`debugD` stay 0.
- **Macro undefined.** Press K2+K3 → `mode`=2 with `moveL`=`moveR`=1. `debugA..D` stay 0 throughout.
